// File: rtl/data_memory_arbiter_pkg.sv
// Shared data-memory constants plus arbiter state/command types.
// The optional statistics counters in data_memory_arbiter are enabled by DATA_MEMORY_ARBITER_STATS_EN.
package data_memory_arbiter_pkg;

    localparam int unsigned RISC_V_DATA_WIDTH         = 32;
    localparam int unsigned DATA_MEMORY_ADDRESS_WIDTH = 10;
    localparam int unsigned DATA_MEMORY_ROM_DEPTH     = 256;
    localparam int unsigned DATA_MEMORY_RAM_DEPTH     = 256;

    // Port index field sized for the largest supported requester count (8).
    localparam int unsigned DMEM_ARB_PORT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dmem_arb_state_t;

    typedef struct packed {
        logic [DMEM_ARB_PORT_W-1:0]           port;
        logic                                 we;
        logic [DATA_MEMORY_ADDRESS_WIDTH-1:0] addr;
        logic [RISC_V_DATA_WIDTH-1:0]         wdata;
        logic                                 err;
    } dmem_arb_cmd_t;

    // ROM is read-only; anything past the RAM window does not exist.
    function automatic logic dmem_access_err(
        input logic                                 we,
        input logic [DATA_MEMORY_ADDRESS_WIDTH-1:0] addr
    );
        logic [DATA_MEMORY_ADDRESS_WIDTH:0] a;
        a = {1'b0, addr};
        return (we && (a < (DATA_MEMORY_ADDRESS_WIDTH+1)'(DATA_MEMORY_ROM_DEPTH))) ||
               (a >= (DATA_MEMORY_ADDRESS_WIDTH+1)'(DATA_MEMORY_ROM_DEPTH + DATA_MEMORY_RAM_DEPTH));
    endfunction

endpackage

// File: rtl/data_memory_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt_c,
    output logic [IDX_W-1:0] idx_c,
    output logic             any_c
);

    localparam int unsigned SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] cand;

    // Scan ports in rotated order starting at ptr, keep the first hit.
    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + SUM_W'(i);
            if (cand >= SUM_W'(N)) begin
                cand = cand - SUM_W'(N);
            end
            if (!any_c && req[cand[IDX_W-1:0]]) begin
                any_c                    = 1'b1;
                idx_c                    = cand[IDX_W-1:0];
                gnt_c[cand[IDX_W-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing the single data_memory port among NUM_PORTS requesters.
// Optional saturating grant/conflict counters: define DATA_MEMORY_ARBITER_STATS_EN.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2
`ifdef DATA_MEMORY_ARBITER_STATS_EN
    ,
    parameter int unsigned STAT_WIDTH = 16
`endif
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic [NUM_PORTS-1:0]                                  req,
    input  logic [NUM_PORTS-1:0]                                  req_we,
    input  logic [NUM_PORTS-1:0][DATA_MEMORY_ADDRESS_WIDTH-1:0]   req_addr,
    input  logic [NUM_PORTS-1:0][RISC_V_DATA_WIDTH-1:0]           req_wdata,
    output logic [NUM_PORTS-1:0]                                  gnt,
    output logic [NUM_PORTS-1:0]                                  rsp_valid,
    output logic                                                  rsp_err,
    output logic [RISC_V_DATA_WIDTH-1:0]                          rsp_rdata,
    output logic [DATA_MEMORY_ADDRESS_WIDTH-1:0]                  mem_address,
    output logic [RISC_V_DATA_WIDTH-1:0]                          mem_w_data,
    output logic                                                  mem_ctrl_w,
    output logic                                                  mem_ctrl_r,
    input  logic [RISC_V_DATA_WIDTH-1:0]                          mem_r_data
`ifdef DATA_MEMORY_ARBITER_STATS_EN
    ,
    output logic [NUM_PORTS-1:0][STAT_WIDTH-1:0]                  stat_grants,
    output logic [STAT_WIDTH-1:0]                                 stat_conflicts
`endif
);

    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    dmem_arb_state_t  state;
    dmem_arb_cmd_t    cmd;
    dmem_arb_cmd_t    new_cmd_c;
    logic [IDX_W-1:0] ptr;

    logic [NUM_PORTS-1:0] arb_gnt_c;
    logic [IDX_W-1:0]     arb_idx_c;
    logic                 arb_any_c;

    rr_arbiter #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (ptr),
        .gnt_c (arb_gnt_c),
        .idx_c (arb_idx_c),
        .any_c (arb_any_c)
    );

    // Command the winning port would present if captured this cycle.
    always_comb begin
        new_cmd_c       = '0;
        new_cmd_c.port  = DMEM_ARB_PORT_W'(arb_idx_c);
        new_cmd_c.we    = req_we[arb_idx_c];
        new_cmd_c.addr  = req_addr[arb_idx_c];
        new_cmd_c.wdata = req_wdata[arb_idx_c];
        new_cmd_c.err   = dmem_access_err(req_we[arb_idx_c], req_addr[arb_idx_c]);
    end

    // Control FSM: outputs are set on the edge entering the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd         <= '0;
            ptr         <= '0;
            gnt         <= '0;
            rsp_valid   <= '0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
            mem_address <= '0;
            mem_w_data  <= '0;
            mem_ctrl_w  <= 1'b0;
            mem_ctrl_r  <= 1'b0;
        end else begin
            gnt        <= '0;
            rsp_valid  <= '0;
            rsp_err    <= 1'b0;
            mem_ctrl_w <= 1'b0;
            mem_ctrl_r <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (arb_any_c) begin
                        cmd         <= new_cmd_c;
                        gnt         <= arb_gnt_c;
                        mem_address <= new_cmd_c.addr;
                        mem_w_data  <= new_cmd_c.wdata;
                        mem_ctrl_r  <= !new_cmd_c.we && !new_cmd_c.err;
                        mem_ctrl_w  <= new_cmd_c.we && !new_cmd_c.err;
                        state       <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    rsp_valid <= NUM_PORTS'(1) << cmd.port;
                    rsp_err   <= cmd.err;
                    rsp_rdata <= (!cmd.we && !cmd.err) ? mem_r_data : '0;
                    ptr       <= (cmd.port == DMEM_ARB_PORT_W'(NUM_PORTS - 1)) ?
                                 '0 : IDX_W'(cmd.port + 1'b1);
                    state     <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DATA_MEMORY_ARBITER_STATS_EN
    // Saturating per-port grant counts and multi-request arbitration counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants    <= '0;
            stat_conflicts <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (gnt[p] && (stat_grants[p] != '1)) begin
                    stat_grants[p] <= stat_grants[p] + STAT_WIDTH'(1);
                end
            end
            if ((state != ACCESS) && ($countones(req) > 1) && (stat_conflicts != '1)) begin
                stat_conflicts <= stat_conflicts + STAT_WIDTH'(1);
            end
        end
    end
`endif

endmodule
